mfp_irq_ctrl: RTL and testbench

16-channel MFP68901-style interrupt controller that consumes the one-cycle interrupt pulses produced by the four timer instances (T_O_PULSE), the GPIP edge detectors and the USART. It holds the enable, pending, in-service and mask register pairs and the vector register, and resolves fixed priority. It drives the active-low CPU interrupt request and answers interrupt-acknowledge cycles with an 8-bit vector. It sits between the timer/GPIP/USART stages and the CPU bus glue inside the MFP top level.

---
 rtl/mfp_irq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mfp_irq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_irq_ctrl.sv
// mfp_irq_ctrl: 16-channel MFP68901-style interrupt controller.
//
// Latches one-cycle interrupt pulses into pending bits, resolves fixed
// priority (channel 15 highest), optionally nests through the in-service
// register (VR S bit), drives an active-low registered IRQ_N and answers
// IACK strobes with a registered 8-bit vector.
//
// Ports:
//   CLK        system clock
//   RST_N      synchronous active-low reset
//   IRQ_SRC    one-cycle interrupt pulses, bit 15 highest priority
//   ADDR       register select (0 IERA .. 8 VR, 9-15 read 0)
//   WE         one-cycle write strobe
//   DAT_I      write data
//   DAT_O      combinational read data of the selected register
//   IACK       one-cycle interrupt-acknowledge strobe
//   VEC_O      registered acknowledged vector
//   VEC_VALID  one-cycle pulse qualifying VEC_O
//   IRQ_N      registered interrupt request, active-low
//
// "A" registers hold channels 15..8, "B" registers hold channels 7..0.
module mfp_irq_ctrl #(
  parameter bit NONE_WINS_IACK = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] IRQ_SRC,
  input  logic [3:0]  ADDR,
  input  logic        WE,
  input  logic [7:0]  DAT_I,
  output logic [7:0]  DAT_O,
  input  logic        IACK,
  output logic [7:0]  VEC_O,
  output logic        VEC_VALID,
  output logic        IRQ_N
);

  typedef enum logic [3:0] {
    REG_IERA = 4'd0,
    REG_IERB = 4'd1,
    REG_IPRA = 4'd2,
    REG_IPRB = 4'd3,
    REG_ISRA = 4'd4,
    REG_ISRB = 4'd5,
    REG_IMRA = 4'd6,
    REG_IMRB = 4'd7,
    REG_VR   = 4'd8
  } reg_sel_e;

  reg_sel_e sel;
  assign sel = reg_sel_e'(ADDR);

  logic [15:0] ier_q, ier_d;
  logic [15:0] ipr_q, ipr_d;
  logic [15:0] isr_q, isr_d;
  logic [15:0] imr_q, imr_d;
  logic [7:0]  vr_q,  vr_d;
  logic [7:0]  vec_q, vec_d;
  logic        vec_valid_q, vec_valid_d;
  logic        irq_n_q, irq_n_d;

  // Per-bit keep masks: a bit written 0 clears, a bit written 1 preserves.
  logic [15:0] ier_keep;
  logic [15:0] ipr_keep;
  logic [15:0] isr_keep;

  logic        s_bit;
  logic [15:0] qual;
  logic        top_found;
  logic [3:0]  top_ch;
  logic [15:0] hi_mask;
  logic        blocked;
  logic        grant;
  logic [15:0] grant_onehot;
  logic        ack;

  assign s_bit = vr_q[3];

  // Register write decode
  always_comb begin
    ier_d    = ier_q;
    imr_d    = imr_q;
    vr_d     = vr_q;
    ier_keep = '1;
    ipr_keep = '1;
    isr_keep = '1;
    if (WE) begin
      case (sel)
        REG_IERA: begin ier_d[15:8] = DAT_I; ier_keep[15:8] = DAT_I; end
        REG_IERB: begin ier_d[7:0]  = DAT_I; ier_keep[7:0]  = DAT_I; end
        REG_IPRA: ipr_keep[15:8] = DAT_I;
        REG_IPRB: ipr_keep[7:0]  = DAT_I;
        REG_ISRA: isr_keep[15:8] = DAT_I;
        REG_ISRB: isr_keep[7:0]  = DAT_I;
        REG_IMRA: imr_d[15:8] = DAT_I;
        REG_IMRB: imr_d[7:0]  = DAT_I;
        REG_VR:   vr_d = DAT_I;
        default:  ;
      endcase
    end
  end

  // Fixed-priority arbitration on the current (pre-edge) register state.
  // Only the highest qualifying channel matters: if it is blocked, every
  // lower channel is blocked by the same in-service bit.
  always_comb begin
    qual      = ipr_q & imr_q;
    top_found = 1'b0;
    top_ch    = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (qual[i]) begin
        top_found = 1'b1;
        top_ch    = i[3:0];
      end
    end
    hi_mask      = 16'hFFFF << top_ch;
    blocked      = s_bit && (|(isr_q & hi_mask));
    grant        = top_found && !blocked;
    grant_onehot = grant ? (16'h0001 << top_ch) : '0;
  end

  assign ack = IACK && grant;

  // Pending/in-service next state. Ordering: software clear, acknowledge
  // clear, then new pulse sets; an IER 0 write drops the pending bit last.
  always_comb begin
    ipr_d = (((ipr_q & ipr_keep) & ~(ack ? grant_onehot : '0))
             | (IRQ_SRC & ier_q)) & ier_keep;
    isr_d = (isr_q & isr_keep) | ((ack && s_bit) ? grant_onehot : '0);
  end

  // Vector / request outputs
  always_comb begin
    vec_d       = vec_q;
    vec_valid_d = 1'b0;
    if (IACK) begin
      if (grant) begin
        vec_d       = {vr_q[7:4], top_ch};
        vec_valid_d = 1'b1;
      end else if (NONE_WINS_IACK) begin
        vec_d       = {vr_q[7:4], 4'h0};
        vec_valid_d = 1'b1;
      end
    end
    irq_n_d = ~grant;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ier_q       <= '0;
      ipr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '0;
      vr_q        <= '0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      irq_n_q     <= 1'b1;
    end else begin
      ier_q       <= ier_d;
      ipr_q       <= ipr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      vr_q        <= vr_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      irq_n_q     <= irq_n_d;
    end
  end

  // Read mux, side-effect free
  always_comb begin
    case (sel)
      REG_IERA: DAT_O = ier_q[15:8];
      REG_IERB: DAT_O = ier_q[7:0];
      REG_IPRA: DAT_O = ipr_q[15:8];
      REG_IPRB: DAT_O = ipr_q[7:0];
      REG_ISRA: DAT_O = isr_q[15:8];
      REG_ISRB: DAT_O = isr_q[7:0];
      REG_IMRA: DAT_O = imr_q[15:8];
      REG_IMRB: DAT_O = imr_q[7:0];
      REG_VR:   DAT_O = vr_q;
      default:  DAT_O = '0;
    endcase
  end

  assign VEC_O     = vec_q;
  assign VEC_VALID = vec_valid_q;
  assign IRQ_N     = irq_n_q;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// tb_mfp_irq_ctrl: self-checking bench for mfp_irq_ctrl.
// Two instances (NONE_WINS_IACK = 0 and 1) share all inputs. A per-channel
// behavioural model predicts every output and register each cycle.
module tb_mfp_irq_ctrl;

  logic        clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [15:0] irq_src = '0;
  logic [3:0]  addr = '0;
  logic        we = 1'b0;
  logic [7:0]  dat_i = '0;
  logic        iack = 1'b0;

  logic [7:0]  dat_o0, vec_o0, dat_o1, vec_o1;
  logic        vv0, vv1, irq_n0, irq_n1;

  mfp_irq_ctrl #(.NONE_WINS_IACK(1'b0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .IRQ_SRC(irq_src), .ADDR(addr), .WE(we),
    .DAT_I(dat_i), .DAT_O(dat_o0), .IACK(iack), .VEC_O(vec_o0),
    .VEC_VALID(vv0), .IRQ_N(irq_n0)
  );

  mfp_irq_ctrl #(.NONE_WINS_IACK(1'b1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .IRQ_SRC(irq_src), .ADDR(addr), .WE(we),
    .DAT_I(dat_i), .DAT_O(dat_o1), .IACK(iack), .VEC_O(vec_o1),
    .VEC_VALID(vv1), .IRQ_N(irq_n1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one flag per channel per register
  bit       m_en[16];
  bit       m_pend[16];
  bit       m_insvc[16];
  bit       m_mask[16];
  logic [7:0] m_vr = '0;
  logic [7:0] m_vec0 = '0, m_vec1 = '0;
  bit       m_vv0 = 0, m_vv1 = 0, m_irqn = 1;

  // Highest pending+unmasked channel, or -1 if none or it is nested out.
  function automatic int m_grant();
    int c = -1;
    for (int i = 15; i >= 0; i--) begin
      if (m_pend[i] && m_mask[i]) begin
        c = i;
        break;
      end
    end
    if (c >= 0 && m_vr[3]) begin
      for (int j = 0; j < 16; j++)
        if (j >= c && m_insvc[j]) return -1;
    end
    return c;
  endfunction

  function automatic logic [7:0] m_read(input int a);
    logic [7:0] v = '0;
    for (int b = 0; b < 8; b++) begin
      int ch = (a % 2 == 0) ? b + 8 : b;
      case (a)
        0, 1: v[b] = m_en[ch];
        2, 3: v[b] = m_pend[ch];
        4, 5: v[b] = m_insvc[ch];
        6, 7: v[b] = m_mask[ch];
        default: ;
      endcase
    end
    if (a == 8) v = m_vr;
    return v;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_en[i] = 0; m_pend[i] = 0; m_insvc[i] = 0; m_mask[i] = 0;
      end
      m_vr = '0; m_vec0 = '0; m_vec1 = '0;
      m_vv0 = 0; m_vv1 = 0; m_irqn = 1;
    end else begin
      int c = m_grant();
      bit s = m_vr[3];
      m_irqn = (c < 0);
      m_vv0 = 0;
      m_vv1 = 0;
      if (iack) begin
        if (c >= 0) begin
          m_vec0 = {m_vr[7:4], 4'(c)};
          m_vec1 = {m_vr[7:4], 4'(c)};
          m_vv0 = 1;
          m_vv1 = 1;
        end else begin
          m_vec1 = {m_vr[7:4], 4'h0};
          m_vv1 = 1;
        end
      end
      for (int i = 0; i < 16; i++) begin
        int off = (i >= 8) ? 0 : 1;
        bit d = dat_i[i % 8];
        bit p = m_pend[i];
        bit sv = m_insvc[i];
        if (we && int'(addr) == 2 + off && !d) p = 0;
        if (iack && c == i) p = 0;
        if (irq_src[i] && m_en[i]) p = 1;
        if (we && int'(addr) == off && !d) p = 0;
        if (we && int'(addr) == 4 + off && !d) sv = 0;
        if (iack && c == i && s) sv = 1;
        if (we && int'(addr) == off) m_en[i] = d;
        if (we && int'(addr) == 6 + off) m_mask[i] = d;
        m_pend[i] = p;
        m_insvc[i] = sv;
      end
      if (we && addr == 4'd8) m_vr = dat_i;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1;
      check($sformatf("rd0_%0d", a), {24'h0, dat_o0}, {24'h0, m_read(a)});
      check($sformatf("rd1_%0d", a), {24'h0, dat_o1}, {24'h0, m_read(a)});
    end
    addr = '0;
  endtask

  task automatic cyc(input logic [15:0] src, input logic w, input logic [3:0] a,
                     input logic [7:0] d, input logic ak, input logic r);
    irq_src = src; we = w; addr = a; dat_i = d; iack = ak; rst_n = r;
    @(posedge clk);
    model_edge();
    #1;
    check("irq_n0", {31'h0, irq_n0}, {31'h0, m_irqn});
    check("irq_n1", {31'h0, irq_n1}, {31'h0, m_irqn});
    check("vv0", {31'h0, vv0}, {31'h0, m_vv0});
    check("vv1", {31'h0, vv1}, {31'h0, m_vv1});
    check("vec0", {24'h0, vec_o0}, {24'h0, m_vec0});
    check("vec1", {24'h0, vec_o1}, {24'h0, m_vec1});
    irq_src = '0; we = 1'b0; iack = 1'b0; rst_n = 1'b1; dat_i = '0;
    read_all();
  endtask

  task automatic idle();                                  cyc('0, 0, 0, 0, 0, 1); endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d); cyc('0, 1, a, d, 0, 1); endtask
  task automatic pulse(input logic [15:0] s);             cyc(s, 0, 0, 0, 0, 1); endtask
  task automatic ackc();                                  cyc('0, 0, 0, 0, 1, 1); endtask

  task automatic peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, {24'h0, dat_o0}, {24'h0, exp});
    addr = '0;
  endtask

  initial begin
    // Reset
    cyc('0, 0, 0, 0, 0, 0);
    cyc('0, 0, 0, 0, 0, 0);
    check("rst_irq_n", {31'h0, irq_n0}, 32'h1);
    check("rst_vec", {24'h0, vec_o0}, 32'h0);

    // Single channel
    wr(4'd1, 8'h20); wr(4'd7, 8'h20); wr(4'd8, 8'h40);
    pulse(16'h0020);
    check("t1_irq_lag", {31'h0, irq_n0}, 32'h1);
    idle();
    check("t1_irq_low", {31'h0, irq_n0}, 32'h0);
    ackc();
    check("t1_vec", {24'h0, vec_o0}, 32'h45);
    check("t1_vv", {31'h0, vv0}, 32'h1);
    peek("t1_iprb", 4'd3, 8'h00);
    idle();
    check("t1_vv_drop", {31'h0, vv0}, 32'h0);
    check("t1_irq_high", {31'h0, irq_n0}, 32'h1);

    // Priority
    wr(4'd0, 8'hFF); wr(4'd1, 8'hFF); wr(4'd6, 8'hFF); wr(4'd7, 8'hFF);
    pulse(16'h2004); idle();
    ackc(); check("pri_13", {24'h0, vec_o0}, 32'h4D);
    ackc(); check("pri_2", {24'h0, vec_o0}, 32'h42);
    idle();

    // S-mode nesting
    wr(4'd8, 8'h48);
    pulse(16'h0010); idle();
    ackc(); check("s_vec4", {24'h0, vec_o0}, 32'h44);
    peek("s_isrb", 4'd5, 8'h10);
    pulse(16'h0008); idle(); idle();
    check("s_blocked", {31'h0, irq_n0}, 32'h1);
    pulse(16'h0200); idle();
    check("s_ch9_irq", {31'h0, irq_n0}, 32'h0);
    ackc(); check("s_vec9", {24'h0, vec_o0}, 32'h49);
    wr(4'd5, 8'hEF); wr(4'd4, 8'hFD); idle();
    check("s_ch3_irq", {31'h0, irq_n0}, 32'h0);
    ackc(); check("s_vec3", {24'h0, vec_o0}, 32'h43);
    idle();

    // Clear races
    cyc(16'h0080, 1, 4'd3, 8'h7F, 0, 1);
    peek("race_iprb", 4'd3, 8'h80);
    wr(4'd3, 8'h7F);
    pulse(16'h0001);
    wr(4'd1, 8'h00);
    peek("race_ier", 4'd3, 8'h00);
    wr(4'd1, 8'hFF);

    // Masked, disabled, spurious
    wr(4'd6, 8'h00);
    pulse(16'h8000); idle(); idle();
    check("mask_irq", {31'h0, irq_n0}, 32'h1);
    peek("mask_ipra", 4'd2, 8'h80);
    wr(4'd1, 8'h00);
    pulse(16'h0002);
    peek("dis_iprb", 4'd3, 8'h00);
    ackc();
    check("spur_vv0", {31'h0, vv0}, 32'h0);
    check("spur_vv1", {31'h0, vv1}, 32'h1);
    check("spur_vec1", {24'h0, vec_o1}, 32'h40);

    // Reset mid-operation
    wr(4'd6, 8'hFF); idle();
    ackc();
    wr(4'd8, 8'h40);
    pulse(16'h8000); idle();
    check("pre_rst_irq", {31'h0, irq_n0}, 32'h0);
    cyc('0, 0, 0, 0, 1, 0);
    check("rst_vv", {31'h0, vv0}, 32'h0);
    check("rst_irq", {31'h0, irq_n0}, 32'h1);
    peek("rst_isra", 4'd4, 8'h00);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [15:0] s = '0;
      logic        w;
      logic [3:0]  a;
      logic [7:0]  d;
      logic        ak;
      logic        r;
      if ($urandom_range(0, 2) == 0) s = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 5) == 0) s = s | (16'h0001 << $urandom_range(0, 15));
      w  = ($urandom_range(0, 3) == 0);
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      if (a < 4'd2 || a == 4'd6 || a == 4'd7) d = d | 8'($urandom);
      ak = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 149) != 0);
      cyc(s, w, a, d, ak, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
